// File: rtl/user_rd_data_checker.sv
// DDR3 read-test receiver: issues NUM_BURSTS read requests of BURST_LEN beats and
// checks every returned beat against an incrementing pattern starting at SEED.
module user_rd_data_checker #(
    parameter int USER_DATA_WIDTH = 8,
    parameter int BURST_LEN       = 1024,
    parameter int NUM_BURSTS      = 4,
    parameter int SEED            = 0,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              ddrc_init_done,
    input  logic                              rd_test_ctrl,
    output logic                              user_ddr3_rd_en,
    input  logic [USER_DATA_WIDTH-1:0]        user_rd_data,
    input  logic                              user_rd_data_valid,
    output logic                              test_busy,
    output logic                              test_done,
    output logic                              test_pass,
    output logic                              timeout_err,
    output logic [ERR_CNT_WIDTH-1:0]          err_cnt,
    output logic [$clog2(NUM_BURSTS+1)-1:0]   burst_cnt
);

    localparam int BCW    = $clog2(NUM_BURSTS + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [BEAT_W-1:0]          BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BCW-1:0]             BURST_LAST = BCW'(NUM_BURSTS - 1);
    localparam logic [TMR_W-1:0]           TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [USER_DATA_WIDTH-1:0] SEED_V     = USER_DATA_WIDTH'(SEED);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                 state;
    logic                       ctrl_d;
    logic                       ctrl_d2;
    logic [USER_DATA_WIDTH-1:0] expected;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [TMR_W-1:0]           timer;

    logic start;
    logic abort;
    logic mismatch;
    logic err_full;

    // Edge-detect flops reset to 1 so a level already high at reset release is not an edge.
    assign start    = ddrc_init_done & ctrl_d & ~ctrl_d2;
    assign abort    = ~rd_test_ctrl | ~ddrc_init_done;
    assign mismatch = (user_rd_data != expected);
    assign err_full = &err_cnt;

    assign user_ddr3_rd_en = (state == REQ) & ~abort;
    assign test_busy       = (state == REQ) | (state == RECV);
    assign test_done       = (state == DONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            ctrl_d      <= 1'b1;
            ctrl_d2     <= 1'b1;
            expected    <= SEED_V;
            beat_cnt    <= '0;
            timer       <= '0;
            err_cnt     <= '0;
            burst_cnt   <= '0;
            timeout_err <= 1'b0;
            test_pass   <= 1'b0;
        end else begin
            ctrl_d  <= rd_test_ctrl;
            ctrl_d2 <= ctrl_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ;
                        err_cnt     <= '0;
                        burst_cnt   <= '0;
                        timeout_err <= 1'b0;
                        beat_cnt    <= '0;
                        timer       <= '0;
                        expected    <= SEED_V;
                        test_pass   <= 1'b0;
                    end
                end
                REQ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state <= RECV;
                        if (user_rd_data_valid && !err_full)
                            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                    end
                end
                RECV: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (user_rd_data_valid) begin
                        if (mismatch && !err_full)
                            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                        expected <= expected + USER_DATA_WIDTH'(1);
                        timer    <= '0;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt  <= '0;
                            burst_cnt <= burst_cnt + BCW'(1);
                            if (burst_cnt == BURST_LAST) begin
                                state     <= DONE;
                                // Include this final beat's own result in the verdict.
                                test_pass <= !mismatch && (err_cnt == '0) && !timeout_err;
                            end else begin
                                state <= REQ;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        test_pass   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    if (user_rd_data_valid && !err_full)
                        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                    if (!rd_test_ctrl)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_rd_data_checker.sv
// Directed bench for user_rd_data_checker with 2 bursts of 16 beats, seed F8, timeout 32.
module tb_user_rd_data_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        ctrl = 1'b0;
    logic        rd_en;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        busy, done, pass, tmo;
    logic [15:0] err;
    logic [1:0]  bc;

    int checks = 0;
    int fails = 0;
    int rd_en_cnt = 0;

    user_rd_data_checker #(
        .USER_DATA_WIDTH(8),
        .BURST_LEN(16),
        .NUM_BURSTS(2),
        .SEED(8'hF8),
        .TIMEOUT_CYCLES(32),
        .ERR_CNT_WIDTH(16)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .ddrc_init_done(init_done),
        .rd_test_ctrl(ctrl),
        .user_ddr3_rd_en(rd_en),
        .user_rd_data(data),
        .user_rd_data_valid(valid),
        .test_busy(busy),
        .test_done(done),
        .test_pass(pass),
        .timeout_err(tmo),
        .err_cnt(err),
        .burst_cnt(bc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_en_cnt <= rd_en_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic arm();
        ctrl = 1'b0;
        repeat (3) @(negedge clk);
        ctrl = 1'b1;
    endtask

    task automatic wait_rd_en(input string name);
        int n = 0;
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_en !== 1'b1) begin
            $display("FAIL %s: rd_en got %b expected 1 within 20 cycles", name, rd_en);
            fails++;
        end
    endtask

    // Beat idx carries pattern F8+idx; indices bad_a/bad_b are corrupted.
    task automatic send_beats(input int first, input int n, input int bad_a, input int bad_b);
        logic [7:0] d;
        for (int i = first; i < first + n; i++) begin
            d = 8'hF8 + 8'(i);
            if (i == bad_a || i == bad_b) d = d ^ 8'h55;
            data  = d;
            valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic do_burst(input string name, input int first, input int n, input int bad_a, input int bad_b);
        wait_rd_en(name);
        @(negedge clk);
        send_beats(first, n, bad_a, bad_b);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rd_en !== 1'b0) begin $display("FAIL reset_rd_en: got %b expected 0", rd_en); fails++; end
        checks++; if ({busy, done, pass, tmo} !== 4'b0) begin $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, tmo}); fails++; end
        checks++; if (err !== 16'd0 || bc !== 2'd0) begin $display("FAIL reset_counts: got err=%0d bc=%0d expected 0/0", err, bc); fails++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_run();
        int r0 = rd_en_cnt;
        arm();
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin $display("FAIL latency_early: rd_en got %b expected 0", rd_en); fails++; end
        @(negedge clk);
        checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin $display("FAIL latency_rd_en: rd_en/busy got %b%b expected 11", rd_en, busy); fails++; end
        do_burst("clean_b1", 0, 16, -1, -1);
        do_burst("clean_b2", 16, 16, -1, -1);
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin $display("FAIL clean_done_pass: got %b%b expected 11", done, pass); fails++; end
        checks++; if (bc !== 2'd2 || err !== 16'd0) begin $display("FAIL clean_counts: got bc=%0d err=%0d expected 2/0", bc, err); fails++; end
        checks++; if (rd_en_cnt - r0 !== 2) begin $display("FAIL clean_rd_en_pulses: got %0d expected 2", rd_en_cnt - r0); fails++; end
        checks++; if (busy !== 1'b0 || tmo !== 1'b0) begin $display("FAIL clean_busy_tmo: got %b%b expected 00", busy, tmo); fails++; end
    endtask

    task automatic test_corrupt();
        arm();
        do_burst("corrupt_b1", 0, 5, 3, 20);
        checks++; if (err !== 16'd1) begin $display("FAIL corrupt_after_beat4: err got %0d expected 1", err); fails++; end
        send_beats(5, 11, 3, 20);
        do_burst("corrupt_b2", 16, 16, 3, 20);
        checks++; if (err !== 16'd2) begin $display("FAIL corrupt_err_cnt: got %0d expected 2", err); fails++; end
        checks++; if (done !== 1'b1 || pass !== 1'b0 || bc !== 2'd2) begin $display("FAIL corrupt_result: got done=%b pass=%b bc=%0d expected 1/0/2", done, pass, bc); fails++; end
    endtask

    task automatic test_timeout();
        arm();
        do_burst("tmo_b1", 0, 16, -1, -1);
        do_burst("tmo_b2", 16, 10, -1, -1);
        repeat (31) @(negedge clk);
        checks++; if (done !== 1'b0 || tmo !== 1'b0) begin $display("FAIL timeout_early: done/tmo got %b%b expected 00", done, tmo); fails++; end
        @(negedge clk);
        checks++; if (done !== 1'b1 || tmo !== 1'b1) begin $display("FAIL timeout_fire: done/tmo got %b%b expected 11", done, tmo); fails++; end
        checks++; if (bc !== 2'd1 || pass !== 1'b0) begin $display("FAIL timeout_result: bc=%0d pass=%b expected 1/0", bc, pass); fails++; end
    endtask

    task automatic test_init_gate();
        int r0;
        ctrl = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        ctrl = 1'b1;
        repeat (4) @(negedge clk);
        init_done = 1'b1;
        r0 = rd_en_cnt;
        repeat (10) @(negedge clk);
        checks++; if (rd_en_cnt - r0 !== 0 || busy !== 1'b0) begin $display("FAIL init_gate_no_start: pulses=%0d busy=%b expected 0/0", rd_en_cnt - r0, busy); fails++; end
        r0 = rd_en_cnt;
        arm();
        do_burst("gate_b1", 0, 16, -1, -1);
        do_burst("gate_b2", 16, 16, -1, -1);
        checks++; if (pass !== 1'b1 || rd_en_cnt - r0 !== 2) begin $display("FAIL init_gate_run: pass=%b pulses=%0d expected 1/2", pass, rd_en_cnt - r0); fails++; end
    endtask

    task automatic test_abort();
        int r0;
        arm();
        do_burst("abort_b1", 0, 5, 2, -1);
        ctrl = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin $display("FAIL abort_state: busy/done/pass got %b%b%b expected 000", busy, done, pass); fails++; end
        checks++; if (err !== 16'd1 || bc !== 2'd0) begin $display("FAIL abort_hold: err=%0d bc=%0d expected 1/0", err, bc); fails++; end
        arm();
        wait_rd_en("abort_restart");
        checks++; if (err !== 16'd0 || bc !== 2'd0) begin $display("FAIL abort_restart_clear: err=%0d bc=%0d expected 0/0", err, bc); fails++; end
        do_burst("abort_b1r", 0, 16, -1, -1);
        do_burst("abort_b2r", 16, 16, -1, -1);
        checks++; if (pass !== 1'b1 || err !== 16'd0) begin $display("FAIL abort_rerun: pass=%b err=%0d expected 1/0", pass, err); fails++; end
        // Abort while in REQ: request pulse is suppressed immediately.
        arm();
        wait_rd_en("abort_req");
        ctrl = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b0) begin $display("FAIL abort_req_rd_en: got %b expected 0", rd_en); fails++; end
        r0 = rd_en_cnt;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_en_cnt - r0 !== 0) begin $display("FAIL abort_req_idle: busy=%b pulses=%0d expected 0/0", busy, rd_en_cnt - r0); fails++; end
    endtask

    task automatic test_reset_mid_run();
        int r0;
        arm();
        do_burst("rst_b1", 0, 3, 1, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rd_en, busy, done, pass, tmo} !== 5'b0) begin $display("FAIL midrst_flags: got %b expected 00000", {rd_en, busy, done, pass, tmo}); fails++; end
        checks++; if (err !== 16'd0 || bc !== 2'd0) begin $display("FAIL midrst_counts: err=%0d bc=%0d expected 0/0", err, bc); fails++; end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_en_cnt;
        repeat (6) @(negedge clk);
        checks++; if (rd_en_cnt - r0 !== 0 || busy !== 1'b0) begin $display("FAIL midrst_level_no_start: pulses=%0d busy=%b expected 0/0", rd_en_cnt - r0, busy); fails++; end
        arm();
        wait_rd_en("stray_req");
        data  = 8'hF8;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (err !== 16'd1) begin $display("FAIL stray_req_err: got %0d expected 1", err); fails++; end
        send_beats(0, 16, -1, -1);
        do_burst("stray_b2", 16, 16, -1, -1);
        checks++; if (err !== 16'd1 || pass !== 1'b0 || done !== 1'b1 || bc !== 2'd2) begin $display("FAIL stray_result: err=%0d pass=%b done=%b bc=%0d expected 1/0/1/2", err, pass, done, bc); fails++; end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_corrupt();
        test_timeout();
        test_init_gate();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
